// File: rtl/strait_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : strait_bist_pkg
// Description : Shared state encoding and mode constants for the STRAIT BIST
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package strait_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        WAIT    = 3'd3,
        COMPARE = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [1:0] MODE_RUN_ALL   = 2'b00;
    localparam logic [1:0] MODE_STOP_FAIL = 2'b01;
    localparam logic [1:0] MODE_LOOP      = 2'b10;

endpackage
`default_nettype wire

// File: rtl/strait_bist_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : strait_bist_sequencer_if
// Description : Control, pattern-memory and result bundle of the BIST
//               sequencer; master is the sequencer, slave its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface strait_bist_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic                     start;
    logic                     abort;
    logic [1:0]               bist_mode;
    logic [ADDR_W-1:0]        loop_addr;
    logic [ADDR_W-1:0]        addr;
    logic                     scan_en;
    logic                     capture_en;
    logic                     wr_en;
    logic [DATA_W-1:0]        expected_p;
    logic [NUM_CH*DATA_W-1:0] actual_p;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [CNT_W-1:0]         error_count;
    logic [ADDR_W-1:0]        fail_addr;
    logic [NUM_CH-1:0]        fail_ch_mask;

    modport master (
        input  start, abort, bist_mode, loop_addr, expected_p, actual_p,
        output addr, scan_en, capture_en, wr_en, busy, done, pass,
               error_count, fail_addr, fail_ch_mask
    );

    modport slave (
        output start, abort, bist_mode, loop_addr, expected_p, actual_p,
        input  addr, scan_en, capture_en, wr_en, busy, done, pass,
               error_count, fail_addr, fail_ch_mask
    );
endinterface
`default_nettype wire

// File: rtl/strait_multi_ch_compare.sv
`default_nettype none
// ============================================================================
// Module      : strait_multi_ch_compare
// Description : Compares every result channel against one expected word.
// Revision    : 1.0 - initial release
// ============================================================================
module strait_multi_ch_compare #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0]        i_expected,
    input  wire logic [NUM_CH*DATA_W-1:0] i_actual,
    output logic      [NUM_CH-1:0]        o_mismatch,
    output logic                          o_any_fail
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign o_mismatch[k] = (i_actual[k*DATA_W +: DATA_W] != i_expected);
    end

    assign o_any_fail = |o_mismatch;

endmodule
`default_nettype wire

// File: rtl/strait_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : strait_bist_sequencer
// Description : Sequences scan patterns through shift/capture/compare and
//               accumulates error count plus first-failure information.
// Revision    : 1.0 - initial release
// ============================================================================
module strait_bist_sequencer
    import strait_bist_pkg::*;
#(
    parameter int NUM_PAT  = 16,
    parameter int ADDR_W   = 4,
    parameter int SCAN_LEN = 8,
    parameter int RESP_LAT = 2,
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 8
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    strait_bist_sequencer_if.master  bif
);

    // One shared counter serves both SHIFT and WAIT; it restarts on each state change.
    localparam int MAX_CNT = (SCAN_LEN > RESP_LAT) ? SCAN_LEN : RESP_LAT;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0]     c_shift_last = CW'(SCAN_LEN - 1);
    localparam logic [CW-1:0]     c_wait_last  = CW'(RESP_LAT - 1);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(NUM_PAT - 1);

    state_e              r_state;
    state_e              w_next;
    logic [CW-1:0]       r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_mode;
    logic [CNT_W-1:0]    r_err;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [NUM_CH-1:0]   r_fail_mask;
    logic                r_first_fail;

    logic [NUM_CH-1:0]   w_mismatch;
    logic                w_any_fail;
    logic                w_idle_or_done;
    logic                w_start_ok;
    logic                w_scan_en;
    logic                w_capture_en;
    logic                w_wr_en;
    logic                w_commit;

    strait_multi_ch_compare #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_compare (
        .i_expected (bif.expected_p),
        .i_actual   (bif.actual_p),
        .o_mismatch (w_mismatch),
        .o_any_fail (w_any_fail)
    );

    assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
    assign w_start_ok     = w_idle_or_done && bif.start && !bif.abort;
    assign w_commit       = (r_state == COMPARE) && !bif.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_scan_en    = 1'b0;
        w_capture_en = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_ok) w_next = SHIFT;
            end
            SHIFT: begin
                w_scan_en = 1'b1;
                if (r_cnt == c_shift_last) w_next = CAPTURE;
            end
            CAPTURE: begin
                w_capture_en = 1'b1;
                w_next       = WAIT;
            end
            WAIT: begin
                if (r_cnt == c_wait_last) w_next = COMPARE;
            end
            COMPARE: begin
                w_wr_en = 1'b1;
                if ((r_mode == MODE_STOP_FAIL) && w_any_fail) w_next = DONE;
                else if (r_mode == MODE_LOOP)                 w_next = NEXT;
                else if (r_addr == c_last_addr)               w_next = DONE;
                else                                          w_next = NEXT;
            end
            NEXT: begin
                w_next = SHIFT;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (bif.abort && !w_idle_or_done) w_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == SHIFT) || (r_state == WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Mode is latched at start so a run cannot change behaviour half-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_mode       <= MODE_RUN_ALL;
            r_err        <= '0;
            r_fail_addr  <= '0;
            r_fail_mask  <= '0;
            r_first_fail <= 1'b0;
        end else if (w_start_ok) begin
            r_addr       <= (bif.bist_mode == MODE_LOOP) ? bif.loop_addr : '0;
            r_mode       <= bif.bist_mode;
            r_err        <= '0;
            r_fail_addr  <= '0;
            r_fail_mask  <= '0;
            r_first_fail <= 1'b0;
        end else if (w_commit) begin
            if (w_any_fail) begin
                if (r_err != {CNT_W{1'b1}}) r_err <= r_err + 1'b1;
                if (!r_first_fail) begin
                    r_fail_addr  <= r_addr;
                    r_fail_mask  <= w_mismatch;
                    r_first_fail <= 1'b1;
                end
            end
            if ((w_next == NEXT) && (r_mode != MODE_LOOP)) r_addr <= r_addr + 1'b1;
        end
    end

    assign bif.addr         = r_addr;
    assign bif.scan_en      = w_scan_en;
    assign bif.capture_en   = w_capture_en;
    assign bif.wr_en        = w_wr_en;
    assign bif.busy         = !w_idle_or_done;
    assign bif.done         = (r_state == DONE);
    assign bif.pass         = (r_state == DONE) && (r_err == '0);
    assign bif.error_count  = r_err;
    assign bif.fail_addr    = r_fail_addr;
    assign bif.fail_ch_mask = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_strait_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_strait_bist_sequencer
// Description : Randomized self-checking bench against a pattern-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strait_bist_sequencer;
    import strait_bist_pkg::*;

    localparam int NUM_PAT  = 16;
    localparam int ADDR_W   = 4;
    localparam int SCAN_LEN = 8;
    localparam int RESP_LAT = 2;
    localparam int NUM_CH   = 16;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 8;
    localparam int PAT_CYC  = SCAN_LEN + 1 + RESP_LAT + 1 + 1;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    strait_bist_sequencer_if #(
        .ADDR_W (ADDR_W), .NUM_CH (NUM_CH), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) bif ();

    strait_bist_sequencer #(
        .NUM_PAT (NUM_PAT), .ADDR_W (ADDR_W), .SCAN_LEN (SCAN_LEN),
        .RESP_LAT (RESP_LAT), .NUM_CH (NUM_CH), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    // Pattern memory and fault injection: a set bit corrupts that channel.
    logic [DATA_W-1:0] exp_tab   [NUM_PAT];
    logic [NUM_CH-1:0] fault_tab [NUM_PAT];

    always_comb begin
        bif.expected_p = exp_tab[bif.addr];
        bif.actual_p   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bif.actual_p[k*DATA_W +: DATA_W] = exp_tab[bif.addr] ^
                (fault_tab[bif.addr][k] ? (32'h8000_0000 | (32'h1 << k)) : 32'h0);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pattern-level reference: which patterns run and what the results are.
    int                m_npat;
    int                m_err;
    logic [ADDR_W-1:0] m_faddr;
    logic [NUM_CH-1:0] m_fmask;
    int                m_addrs[$];

    task automatic model(input logic [1:0] mode);
        m_addrs.delete();
        m_npat  = 0;
        m_err   = 0;
        m_faddr = '0;
        m_fmask = '0;
        for (int a = 0; a < NUM_PAT; a++) begin
            m_addrs.push_back(a);
            m_npat++;
            if (fault_tab[a] != '0) begin
                if (m_err == 0) begin
                    m_faddr = ADDR_W'(a);
                    m_fmask = fault_tab[a];
                end
                if (m_err < CNT_MAX) m_err++;
                if (mode == 2'b01) break;
            end
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bif.addr, bif.scan_en, bif.capture_en, bif.wr_en, bif.busy,
                    bif.done, bif.pass, bif.error_count, bif.fail_addr, bif.fail_ch_mask});
    endfunction

    task automatic pulse_start(input logic [1:0] mode);
        @(negedge clk);
        bif.bist_mode = mode;
        bif.start     = 1'b1;
        @(negedge clk);
        bif.start     = 1'b0;
    endtask

    // Runs one non-loop pass and checks it against the model.
    task automatic run_check(input string nm, input logic [1:0] mode, input int busy_start_at);
        int busy_cyc, scans, caps, bad, timeout;
        int got_q[$];
        model(mode);
        pulse_start(mode);
        busy_cyc = 0; scans = 0; caps = 0; bad = 0; timeout = 1;
        for (int n = 0; n < 5000; n++) begin
            if (bif.done) begin
                timeout = 0;
                break;
            end
            busy_cyc++;
            if (!bif.busy) bad++;
            if (bif.scan_en) scans++;
            if (bif.capture_en) begin
                caps++;
                got_q.push_back(int'(bif.addr));
            end
            bif.start = (n == busy_start_at);
            @(negedge clk);
        end
        bif.start = 1'b0;
        if (got_q.size() != m_addrs.size()) bad++;
        else foreach (got_q[i]) if (got_q[i] != m_addrs[i]) bad++;
        chk_eq({nm, ".timeout"},   64'(timeout), 64'd0);
        chk_eq({nm, ".latency"},   64'(busy_cyc), 64'(m_npat * PAT_CYC - 1));
        chk_eq({nm, ".scan_cyc"},  64'(scans), 64'(m_npat * SCAN_LEN));
        chk_eq({nm, ".captures"},  64'(caps), 64'(m_npat));
        chk_eq({nm, ".addr_seq"},  64'(bad), 64'd0);
        chk_eq({nm, ".err_cnt"},   64'(bif.error_count), 64'(m_err));
        chk_eq({nm, ".fail_addr"}, 64'(bif.fail_addr), 64'(m_faddr));
        chk_eq({nm, ".fail_mask"}, 64'(bif.fail_ch_mask), 64'(m_fmask));
        chk_eq({nm, ".pass"},      64'(bif.pass), 64'(m_err == 0));
        chk_eq({nm, ".end_addr"},  64'(bif.addr), 64'(m_npat - 1));
    endtask

    initial begin
        int caps, bad, guard;
        logic [1:0] rmode;
        bif.start     = 1'b0;
        bif.abort     = 1'b0;
        bif.bist_mode = 2'b00;
        bif.loop_addr = '0;
        for (int a = 0; a < NUM_PAT; a++) begin
            exp_tab[a]   = $urandom;
            fault_tab[a] = '0;
        end

        #1 rst_n = 1'b0;
        #11;
        chk_eq("reset.outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All patterns pass
        run_check("allpass", 2'b00, -1);

        // Two faulty patterns, with a stray start while busy
        fault_tab[5] = 16'h0008;
        fault_tab[9] = 16'h0001;
        run_check("faults_m00", 2'b00, 20);
        chk_eq("faults_m00.err_abs", 64'(bif.error_count), 64'd2);
        chk_eq("faults_m00.fa_abs",  64'(bif.fail_addr), 64'd5);

        // Stop on first fail
        run_check("faults_m01", 2'b01, -1);
        chk_eq("faults_m01.addr_abs", 64'(bif.addr), 64'd5);

        // start together with abort in DONE must not restart
        @(negedge clk);
        bif.start = 1'b1;
        bif.abort = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        bif.abort = 1'b0;
        chk_eq("abort_start.done", 64'(bif.done), 64'd1);
        chk_eq("abort_start.results",
               64'({bif.addr, bif.error_count, bif.fail_addr, bif.fail_ch_mask}),
               64'({4'd5, 8'd1, 4'd5, 16'h0008}));
        @(negedge clk);
        chk_eq("abort_start.still_done", 64'(bif.done), 64'd1);

        // Loop mode with a failure every iteration until the counter saturates
        for (int a = 0; a < NUM_PAT; a++) fault_tab[a] = '0;
        fault_tab[7]  = NUM_CH'($urandom_range(1, 65535));
        bif.loop_addr = 4'd7;
        pulse_start(2'b10);
        caps = 0; bad = 0; guard = 0;
        while (caps < 300 && guard < 300 * PAT_CYC + 100) begin
            if (bif.addr != 4'd7) bad++;
            if (bif.capture_en) caps++;
            guard++;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk_eq("loop.iterations", 64'(caps), 64'd300);
        chk_eq("loop.addr_held",  64'(bad), 64'd0);
        chk_eq("loop.busy",       64'(bif.busy), 64'd1);
        chk_eq("loop.err_sat",    64'(bif.error_count), 64'(CNT_MAX));
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        chk_eq("loop.abort_done", 64'(bif.done), 64'd1);
        chk_eq("loop.abort_strobes",
               64'({bif.scan_en, bif.capture_en, bif.wr_en}), 64'd0);
        chk_eq("loop.fail_info",
               64'({bif.fail_addr, bif.fail_ch_mask}), 64'({4'd7, fault_tab[7]}));

        // Asynchronous reset in the middle of pattern 3's shift
        pulse_start(2'b00);
        guard = 0;
        while (!(bif.addr == 4'd3 && bif.scan_en) && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        chk_eq("rst_mid.reached", 64'(guard < 1000), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_mid.outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_rst", 2'b00, -1);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NUM_PAT; a++) begin
                exp_tab[a]   = $urandom;
                fault_tab[a] = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom_range(1, 65535)) : '0;
            end
            case ($urandom_range(0, 2))
                0:       rmode = 2'b00;
                1:       rmode = 2'b01;
                default: rmode = 2'b11;
            endcase
            run_check($sformatf("rand%0d_m%0d", r, rmode), rmode, int'($urandom_range(0, 60)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
